// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD widths, constants and types
package bcd_pkg;

   localparam int BCD_W    = 4;
   localparam int BCD_MAX  = 9;
   localparam int BCD_CORR = 6;

   typedef logic [BCD_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD add cell with >9 correction
module bcd_digit_add
   import bcd_pkg::*;
(
   input  digit_t x,
   input  digit_t y,
   input  logic   ci,
   output digit_t d,
   output logic   co
);

   logic [BCD_W:0] s;
   logic [BCD_W:0] s_corr;

   // Binary digit sum, then the +6 decimal correction whenever it passes 9.
   // Non-BCD inputs take the same path, so 0xF+0+0 yields digit 5, carry 1.
   always_comb begin
      s      = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
      s_corr = s + (BCD_W+1)'(BCD_CORR);
      co     = (s > (BCD_W+1)'(BCD_MAX));
      d      = co ? s_corr[BCD_W-1:0] : s[BCD_W-1:0];
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial N-digit BCD adder (optional BCD_INPUT_CHECK_EN)
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter  int DIGITS = 4,
   localparam int IDXW   = $clog2(DIGITS+1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W = BCD_W * DIGITS;

   state_t          state, state_nxt;
   logic [W-1:0]    a_sh, b_sh, res, res_nxt;
   logic            c;
   logic [IDXW-1:0] cnt;
   digit_t          dg;
   logic            co;

   // One shared digit cell, fed from the low digit of the operand shifters.
   bcd_digit_add u_cell (
      .x  (a_sh[BCD_W-1:0]),
      .y  (b_sh[BCD_W-1:0]),
      .ci (c),
      .d  (dg),
      .co (co)
   );

   // New digits enter from the MSB side, so after DIGITS shifts digit 0 sits at the bottom.
   generate
      if (DIGITS == 1) begin : g_res_one
         assign res_nxt = dg;
      end else begin : g_res_many
         assign res_nxt = {dg, res[W-1:BCD_W]};
      end
   endgenerate

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: start only counts in IDLE; DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == IDXW'(DIGITS-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands on start, ripple one digit per RUN cycle, publish in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  c    <= cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> BCD_W;
               b_sh <= b_sh >> BCD_W;
               res  <= res_nxt;
               c    <= co;
               cnt  <= cnt + 1'b1;
            end
            DONE: begin
               sum  <= res;
               cout <= c;
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_INPUT_CHECK_EN
   logic flag;

   // Sticky non-BCD detector over the digits actually consumed; err follows sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag <= 1'b0;
         err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) flag <= 1'b0;
            RUN:  if ((a_sh[BCD_W-1:0] > BCD_W'(BCD_MAX)) ||
                      (b_sh[BCD_W-1:0] > BCD_W'(BCD_MAX))) flag <= 1'b1;
            DONE: err <= flag;
            default: ;
         endcase
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - scoreboard bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;
   localparam int LAT    = DIGITS + 1;

`ifdef BCD_INPUT_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        busy, done, cout, err;
   logic [15:0] sum;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("sum", {16'd0, sum}, {16'd0, e.sum});
            check("cout", {31'd0, cout}, {31'd0, e.cout});
            check("err", {31'd0, err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      #1;
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] es, input logic ec, input logic ee);
      exp_t e;
      a = av; b = bv; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e.sum = es; e.cout = ec; e.err = ee; e.cyc = cyc + LAT;
      sb.push_back(e);
      a = 16'hffff; b = 16'hffff; cin = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         check("busy_during_op", {31'd0, busy}, 32'd1);
      end
      wait_drain();
   endtask

   initial begin
      exp_t e;
      int   k;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_cout", {31'd0, cout}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1;

      run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

      // start held high: second op only from IDLE after done, mid-op change of a ignored
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      k = cyc;
      e.sum = 16'h3333; e.cout = 1'b0; e.err = 1'b0; e.cyc = k + LAT;
      sb.push_back(e);
      repeat (2) @(posedge clk);
      #1 a = 16'h5555;
      repeat (4) @(posedge clk);
      #1;
      check("held_start_edge", cyc, k + DIGITS + 2);
      start = 1'b0;
      e.sum = 16'h7777; e.cout = 1'b0; e.err = 1'b0; e.cyc = cyc + LAT;
      sb.push_back(e);
      wait_drain();
      repeat (3) @(posedge clk);
      #1 check("no_third_op", {31'd0, busy}, 32'd0);

      // reset on the second RUN cycle abandons the operation
      a = 16'h0123; b = 16'h0456; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_sum", {16'd0, sum}, 32'd0);
      check("abort_cout", {31'd0, cout}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      run_op(16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);

      // non-BCD digit: corrected result, err only when the checker is built
      run_op(16'h00f0, 16'h0000, 1'b0, 16'h0150, 1'b0, ERR_ON);
      run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
